quiz32_arb: RTL and testbench
=============================

# quiz32_arb

Round-robin arbiter and sequencer that shares one quiz32 burst-pattern engine between N requesters. It selects a winner and pulses the engine trigger `a` for one cycle. It holds the winner's grant for the engine's full occupancy, then signals completion. It sits between the requesting blocks and the single quiz32 engine instance, and it is the only driver of that engine's `a` input.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `BURST_LEN`, default 3: cycles the engine stays out of its idle state after accepting a trigger.
- `CLK`  input  1: rising-edge clock; shared with the engine.
- `R`  input  1: synchronous reset, active-high. It is sampled only on the rising edge of `CLK`.
- `req`  input  N: request vector. Requester i holds `req[i]` high until it sees `done[i]`.
- `gnt`  output  N: one-hot grant. High from the ISSUE cycle through the DONE cycle inclusive.
- `a`  output  1: engine trigger. One-cycle pulse, high only in ISSUE.
- `busy`  output  1: high whenever the state is not IDLE.
- `done`  output  N: one-cycle pulse to the winner in the DONE cycle.

## Operation
- All outputs are registered or Moore-decoded from state; there are no combinational paths from `req` to any output.
- Reset values: state=IDLE, `gnt`=0, `a`=0, `busy`=0, `done`=0, priority pointer `ptr`=0, occupancy counter=0.
- States and transitions:
  - IDLE: if `req`≠0, latch the winner into `gnt` and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `a`=1. Set counter=BURST_LEN-1. Set `ptr`=(winner+1) mod N. Go to RUN.
  - RUN: counter decrements by 1 per cycle. When counter=0, go to DONE.
  - DONE: `done` = `gnt` for one cycle. Clear `gnt` on exit. Go to IDLE.
- Winner selection (default): the first set bit of `req`, scanning from index `ptr` upward with wrap at N-1→0.
- Counter width is clog2(BURST_LEN)+1. The counter never underflows; the RUN exit is taken at 0.
- Dropping `req[winner]` after ISSUE is ignored and the burst completes. New requests arriving during ISSUE, RUN or DONE are not sampled until the next IDLE.
- A single requester holding `req` continuously is re-served every BURST_LEN+3 cycles.
- Reset asserted in any state returns every register to its reset value at that edge, with no `done` pulse. The engine shares `R` and also returns to its idle state.

## Timing
- Request seen in IDLE at edge k → ISSUE in cycle k+1 (`a`=1, `gnt` valid).
- Engine leaves idle at edge k+2. RUN occupies cycles k+2 .. k+1+BURST_LEN.
- DONE occurs in cycle k+2+BURST_LEN, which is the cycle the engine is back in its idle state.
- Back in IDLE at cycle k+3+BURST_LEN. The earliest next `a` is at cycle k+4+BURST_LEN, so the engine is never triggered while busy.
- Grant-to-done latency is BURST_LEN+1 cycles. Request-to-done latency is BURST_LEN+2 cycles.
- `a` is never high for two consecutive cycles.
- `gnt` is one-hot or zero in every cycle.

## Configuration
- `QUIZ32_ARB_FIXED_PRIO_EN` undefined (default): round-robin selection as described above, and the `ptr` register is present.
- `QUIZ32_ARB_FIXED_PRIO_EN` defined: the lowest index with `req` set always wins. The `ptr` register is not implemented. All timing is unchanged.

## Test plan
- Reset: hold `R`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `a`=0, `busy`=0, `done`=0 throughout the reset window.
- Single request: `req`=4'b0100 asserted at edge 0 →
  - `a` and `gnt`=4'b0100 in cycle 1;
  - `busy` high in cycles 1–5;
  - `done`=4'b0100 in cycle 5;
  - `gnt`=0 and state IDLE in cycle 6.
- Round-robin: `req`=4'b1111 held constant → grant order 0,1,2,3,0, with consecutive `a` pulses exactly 6 cycles apart.
- Request drop: `req[1]` deasserted during RUN → the burst still completes and `done[1]` pulses in the scheduled DONE cycle.
- Reset mid-burst: `R`=1 during the second RUN cycle →
  - next cycle: all outputs 0 and no `done` pulse;
  - after `R` falls, `req`=4'b1010 → requester 1 is granted first (`ptr` was reset to 0).
- Fixed priority (build with `QUIZ32_ARB_FIXED_PRIO_EN`): `req`=4'b1011 held constant → requester 0 is granted on every burst, and requesters 1 and 3 are never granted.

Source files
------------

// File: rtl/quiz32_arb.sv
// Round-robin arbiter that shares one quiz32 burst engine among N requesters.
// Define QUIZ32_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no ptr register).
module quiz32_arb #(
   parameter int N         = 4,
   parameter int BURST_LEN = 3
) (
   input  logic         CLK,
   input  logic         R,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt,
   output logic         a,
   output logic         busy,
   output logic [N-1:0] done
);

   localparam int PW = $clog2(N);
   localparam int CW = $clog2(BURST_LEN) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pick;
   logic          found;
   int            scan;

`ifndef QUIZ32_ARB_FIXED_PRIO_EN
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win_q, win_d;
`endif

   // Winner search: first set request starting at the priority origin, wrapping at N-1.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      scan  = 0;
      for (int k = 0; k < N; k++) begin
`ifdef QUIZ32_ARB_FIXED_PRIO_EN
         scan = k;
`else
         scan = int'(ptr_q) + k;
         if (scan >= N) scan = scan - N;
`endif
         if (!found && req[scan[PW-1:0]]) begin
            found = 1'b1;
            pick  = scan[PW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
`ifndef QUIZ32_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
      win_d   = win_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               gnt_d   = N'(1) << pick;
`ifndef QUIZ32_ARB_FIXED_PRIO_EN
               win_d   = pick;
`endif
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CW'(BURST_LEN - 1);
`ifndef QUIZ32_ARB_FIXED_PRIO_EN
            ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
`endif
            state_d = S_RUN;
         end
         S_RUN: begin
            // Exit is taken at zero so the counter never wraps.
            if (cnt_q == '0) state_d = S_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_DONE: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (R) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         cnt_q   <= '0;
`ifndef QUIZ32_ARB_FIXED_PRIO_EN
         ptr_q   <= '0;
         win_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
`ifndef QUIZ32_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
         win_q   <= win_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign a    = (state_q == S_ISSUE);
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE) ? gnt_q : '0;

endmodule

// File: tb/tb_quiz32_arb.sv
// Scoreboard bench for quiz32_arb: stimulus queues expected trigger/done events,
// a negedge monitor pops and compares them whenever the DUT pulses a or done.
module tb_quiz32_arb;

   localparam int N  = 4;
   localparam int BL = 3;

   logic         CLK = 1'b0;
   logic         R;
   logic [N-1:0] req;
   logic [N-1:0] gnt;
   logic         a;
   logic         busy;
   logic [N-1:0] done;

   quiz32_arb #(.N(N), .BURST_LEN(BL)) dut (
      .CLK  (CLK),
      .R    (R),
      .req  (req),
      .gnt  (gnt),
      .a    (a),
      .busy (busy),
      .done (done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int           cyc;
      logic [N-1:0] val;
   } exp_t;

   exp_t a_q[$];
   exp_t d_q[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   bit   mon_en = 1'b0;
   logic a_prev = 1'b0;

   // cyc equals k during the interval following rising edge k
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge CLK);
   endtask

   task automatic push_burst(input int s, input logic [N-1:0] g, input bit with_done);
      exp_t e;
      e.cyc = s;
      e.val = g;
      a_q.push_back(e);
      if (with_done) begin
         e.cyc = s + BL + 1;
         d_q.push_back(e);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (mon_en) begin
         chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
         chk("a_not_back_to_back", {31'd0, a & a_prev}, 32'd0);
         a_prev = a;
         if (a === 1'b1) begin
            if (a_q.size() == 0) chk("unexpected_a", {28'd0, gnt}, 32'd0);
            else begin
               e = a_q.pop_front();
               chk("a_pulse_cycle_gnt", {cyc[27:0], gnt}, {e.cyc[27:0], e.val});
            end
         end
         if (done !== '0) begin
            if (d_q.size() == 0) chk("unexpected_done", {28'd0, done}, 32'd0);
            else begin
               e = d_q.pop_front();
               chk("done_pulse_cycle_val", {cyc[27:0], done}, {e.cyc[27:0], e.val});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      R   = 1'b1;
      req = 4'b1111;

      // reset window: two edges with R high and every request raised
      for (int i = 1; i <= 2; i++) begin
         wait_to(i);
         chk("rst_gnt", {28'd0, gnt}, 32'd0);
         chk("rst_a", {31'd0, a}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_done", {28'd0, done}, 32'd0);
      end
      R      = 1'b0;
      req    = '0;
      mon_en = 1'b1;

      // round-robin with all requests held: 0,1,2,3,0 six cycles apart
      wait_to(3);
      req = 4'b1111;
      s   = cyc + 1;
      for (int j = 0; j < 5; j++) begin
`ifdef QUIZ32_ARB_FIXED_PRIO_EN
         push_burst(s + 6 * j, 4'b0001, 1'b1);
`else
         push_burst(s + 6 * j, 4'b0001 << (j % 4), 1'b1);
`endif
      end
      wait_to(s + 28);
      req = '0;
      wait_to(s + 29);

      // single request: busy over ISSUE..DONE, idle afterwards
      req = 4'b0100;
      s   = cyc + 1;
      push_burst(s, 4'b0100, 1'b1);
      for (int i = 0; i < 5; i++) begin
         wait_to(s + i);
         chk("single_busy", {31'd0, busy}, 32'd1);
         chk("single_gnt", {28'd0, gnt}, 32'h4);
      end
      req = '0;
      wait_to(s + 5);
      chk("single_gnt_cleared", {28'd0, gnt}, 32'd0);
      chk("single_idle", {31'd0, busy}, 32'd0);

      // request dropped during RUN still completes on schedule
      req = 4'b0010;
      s   = cyc + 1;
      push_burst(s, 4'b0010, 1'b1);
      wait_to(s + 1);
      req = '0;
      wait_to(s + 5);
      chk("drop_idle", {31'd0, busy}, 32'd0);

      // reset in the second RUN cycle aborts silently and clears ptr
      req = 4'b1000;
      s   = cyc + 1;
      push_burst(s, 4'b1000, 1'b0);
      wait_to(s + 2);
      R = 1'b1;
      wait_to(s + 3);
      chk("midrst_gnt", {28'd0, gnt}, 32'd0);
      chk("midrst_a", {31'd0, a}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {28'd0, done}, 32'd0);
      R   = 1'b0;
      req = 4'b1010;
      push_burst(s + 4, 4'b0010, 1'b1);
      wait_to(s + 8);
      req = '0;
      wait_to(s + 9);

      // req=1011 held: round-robin from ptr=2 gives 3,0,1; fixed priority gives 0,0,0
      req = 4'b1011;
      s   = cyc + 1;
`ifdef QUIZ32_ARB_FIXED_PRIO_EN
      push_burst(s,      4'b0001, 1'b1);
      push_burst(s + 6,  4'b0001, 1'b1);
      push_burst(s + 12, 4'b0001, 1'b1);
`else
      push_burst(s,      4'b1000, 1'b1);
      push_burst(s + 6,  4'b0001, 1'b1);
      push_burst(s + 12, 4'b0010, 1'b1);
`endif
      wait_to(s + 16);
      req = '0;
      wait_to(s + 19);

      chk("a_queue_drained", a_q.size(), 32'd0);
      chk("done_queue_drained", d_q.size(), 32'd0);
      chk("final_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
